// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Two-stage carry-lookahead adder/subtractor with valid/ready handshakes
//   on both sides.
//   Stage 1 forms the effective operand, per-bit generate/propagate and
//   per-group generate/propagate.
//   Stage 2 resolves every group carry by lookahead and registers the
//   result flags.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : operand set presented
//   in_ready   : operand set accepted this cycle (combinational on out_ready)
//   a, b       : WIDTH-bit operands
//   cin        : carry-in, add mode only
//   sub        : 0 = add, 1 = subtract (a + ~b + 1)
//   out_valid  : result presented
//   out_ready  : downstream consumer takes the result
//   sum_output : {carry_out, sum}
//   overflow   : two's-complement signed overflow
//   zero       : sum[WIDTH-1:0] == 0
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum_output,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / BLOCK;

  // Group generate/propagate from the bit-level terms of one group.
  // Returns {group_generate, group_propagate}.
  function automatic logic [1:0] group_gp(input logic [BLOCK-1:0] g_in,
                                          input logic [BLOCK-1:0] p_in);
    logic gg;
    logic gp;
    gg = 1'b0;
    gp = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      gg = g_in[i] | (p_in[i] & gg);
      gp = gp & p_in[i];
    end
    return {gg, gp};
  endfunction

  // Handshake control
  logic s1_valid_r;
  logic s2_valid_r;
  logic s1_adv_s;
  logic s2_adv_s;

  // Stage 1 combinational terms
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] bit_g_s;
  logic [WIDTH-1:0] bit_p_s;
  logic [NG-1:0]    grp_g_s;
  logic [NG-1:0]    grp_p_s;
  logic             c0_s;

  // Stage 1 registers
  logic [WIDTH-1:0] g_r;
  logic [WIDTH-1:0] p_r;
  logic [NG-1:0]    gg_r;
  logic [NG-1:0]    gp_r;
  logic             c0_r;

  // Stage 2 combinational terms
  logic [NG:0]      grp_c_s;
  logic             term_s;
  logic             acc_s;
  logic             bit_c_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             zero_s;

  // Stage 2 registers
  logic [WIDTH:0]   sum_r;
  logic             ovf_r;
  logic             zero_r;

  // Advance conditions: a stage moves when it is empty or its successor moves.
  always_comb begin
    s2_adv_s = ~s2_valid_r | out_ready;
    s1_adv_s = ~s1_valid_r | s2_adv_s;
  end

  assign in_ready   = s1_adv_s;
  assign out_valid  = s2_valid_r;
  assign sum_output = sum_r;
  assign overflow   = ovf_r;
  assign zero       = zero_r;

  // Stage 1 combinational: effective operand, bit and group G/P.
  always_comb begin
    grp_g_s = {NG{1'b0}};
    grp_p_s = {NG{1'b0}};
    if (sub) begin
      b_eff_s = ~b;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = b;
      c0_s    = cin;
    end
    bit_g_s = a & b_eff_s;
    bit_p_s = a | b_eff_s;
    for (int k = 0; k < NG; k++) begin
      {grp_g_s[k], grp_p_s[k]} = group_gp(bit_g_s[k*BLOCK +: BLOCK],
                                          bit_p_s[k*BLOCK +: BLOCK]);
    end
  end

  // Stage 1 registers; data captured only for a real transfer so idle
  // operand values never disturb the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      g_r        <= {WIDTH{1'b0}};
      p_r        <= {WIDTH{1'b0}};
      gg_r       <= {NG{1'b0}};
      gp_r       <= {NG{1'b0}};
      c0_r       <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        g_r  <= bit_g_s;
        p_r  <= bit_p_s;
        gg_r <= grp_g_s;
        gp_r <= grp_p_s;
        c0_r <= c0_s;
      end
    end
  end

  // Stage 2 combinational: each group carry is a flat sum of products over
  // the group G/P and c0, so no carry ripples from one group to the next.
  // Inside a group the bit carries start from that group's lookahead carry.
  always_comb begin
    grp_c_s = {(NG+1){1'b0}};
    term_s  = 1'b0;
    acc_s   = 1'b0;
    bit_c_s = 1'b0;
    sum_s   = {WIDTH{1'b0}};
    for (int k = 0; k <= NG; k++) begin
      acc_s = c0_r;
      for (int m = 0; m < k; m++) begin
        acc_s = acc_s & gp_r[m];
      end
      for (int j = 0; j < k; j++) begin
        term_s = gg_r[j];
        for (int m = j + 1; m < k; m++) begin
          term_s = term_s & gp_r[m];
        end
        acc_s = acc_s | term_s;
      end
      grp_c_s[k] = acc_s;
    end
    for (int k = 0; k < NG; k++) begin
      bit_c_s = grp_c_s[k];
      for (int i = 0; i < BLOCK; i++) begin
        // p & ~g is the half-sum a ^ b'
        sum_s[k*BLOCK+i] = (p_r[k*BLOCK+i] & ~g_r[k*BLOCK+i]) ^ bit_c_s;
        bit_c_s          = g_r[k*BLOCK+i] | (p_r[k*BLOCK+i] & bit_c_s);
      end
    end
    // Operand signs are equal when both are 1 (g) or both are 0 (~p);
    // g then carries that common sign.
    ovf_s  = (g_r[WIDTH-1] | ~p_r[WIDTH-1]) & (sum_s[WIDTH-1] ^ g_r[WIDTH-1]);
    zero_s = ~(|sum_s);
  end

  // Stage 2 registers; result held while stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      sum_r      <= {(WIDTH+1){1'b0}};
      ovf_r      <= 1'b0;
      zero_r     <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        sum_r  <= {grp_c_s[NG], sum_s};
        ovf_r  <= ovf_s;
        zero_r <= zero_s;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder (WIDTH=16, BLOCK=4).
// Stimulus pushes expected results into a scoreboard queue; an independent
// monitor pops and compares on every output transfer.
module tb_pipelined_cla_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W:0] sum;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum_output;
  logic         overflow;
  logic         zero;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   results = 0;
  logic rand_ready_en = 1'b0;

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_output(sum_output), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t   e;
    longint ua, ub, us, sa, sb, ss;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (sv) begin
      us = ua + (longint'(65536) - ub);  // carry set exactly when a >= b
      ss = sa - sb;
    end else begin
      us = ua + ub + longint'(cv);
      ss = sa + sb + longint'(cv);
    end
    e.sum  = us[W:0];
    e.ovf  = (ss > longint'(32767)) || (ss < -longint'(32768));
    e.zero = (us[W-1:0] == 16'h0000);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one operand set starting at a negedge; returns at the negedge
  // following acceptance with in_valid lowered.
  task automatic offer(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv, input exp_t e);
    int n;
    n = 0;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    forever begin
      #2;
      if (in_ready === 1'b1) begin
        sb_q.push_back(e);
        accepted++;
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready, expected acceptance");
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h, expected none", sum_output);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sum_output", 32'(sum_output), 32'(e.sum));
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("zero", 32'(zero), 32'(e.zero));
          results++;
        end
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready_en) out_ready = 1'($urandom);
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum_output", 32'(sum_output), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Wrap to zero, with latency check
    offer(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{17'h10000, 1'b0, 1'b1});
    #2;
    check("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #2;
    check("latency_2", 32'(out_valid), 32'd1);
    @(negedge clk);
    offer(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{17'h08000, 1'b1, 1'b0});
    offer(16'h1234, 16'h4321, 1'b1, 1'b0, '{17'h05556, 1'b0, 1'b0});
    offer(16'h0005, 16'h0007, 1'b1, 1'b1, '{17'h0FFFE, 1'b0, 1'b0});
    offer(16'h8000, 16'h0001, 1'b0, 1'b1, '{17'h17FFF, 1'b1, 1'b0});
    drain();

    // Backpressure: only two accepted, outputs stable
    @(negedge clk);
    out_ready = 1'b0;
    offer(16'h0001, 16'h0002, 1'b0, 1'b0, '{17'h00003, 1'b0, 1'b0});
    offer(16'h0010, 16'h0020, 1'b0, 1'b0, '{17'h00030, 1'b0, 1'b0});
    a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum_stable", 32'(sum_output), 32'h00003);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2;
    check("resume_in_ready", 32'(in_ready), 32'd1);
    check("resume_out_valid_0", 32'(out_valid), 32'd1);
    sb_q.push_back('{17'h00300, 1'b0, 1'b0});
    accepted++;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check("resume_out_valid_1", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    check("resume_out_valid_2", 32'(out_valid), 32'd1);
    @(negedge clk);
    drain();

    // Reset with two operations in flight
    out_ready = 1'b0;
    offer(16'h1111, 16'h2222, 1'b0, 1'b0, '{17'h03333, 1'b0, 1'b0});
    offer(16'h4444, 16'h1111, 1'b0, 1'b1, '{17'h13333, 1'b0, 1'b0});
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum_output), 32'd0);
    sb_q.delete();
    accepted = results;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #2;
    check("in_ready_after_midrst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      check("no_stale_result", 32'(out_valid), 32'd0);
    end
    @(negedge clk);

    // Random traffic with random backpressure
    rand_ready_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] av, bv;
      logic cv, sv;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        @(negedge clk);
      end
      av = 16'($urandom);
      bv = 16'($urandom);
      cv = 1'($urandom);
      sv = 1'($urandom);
      offer(av, bv, cv, sv, model(av, bv, cv, sv));
    end
    rand_ready_en = 1'b0;
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    drain();
    check("result_count", 32'(results), 32'(accepted));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand width in bits (legal range 4..64, multiple of BLOCK).
REQ-002 The module SHALL have parameter BLOCK, default 4, giving the lookahead group width in bits (legal values 2, 4, 8).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the operand set is accepted this cycle.
REQ-007 The module SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The module SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-009 The module SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-010 The module SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-012 The module SHALL have port sum_output, output, WIDTH+1 bits: {carry_out, sum}.
REQ-013 The module SHALL have port overflow, output, 1 bit: two's-complement signed overflow.
REQ-014 The module SHALL have port zero, output, 1 bit: sum[WIDTH-1:0] equals 0.

Function
REQ-015 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1, and likewise where out_valid and out_ready are both 1.
REQ-016 Add mode SHALL compute a + b + cin; subtract mode SHALL compute a + ~b + 1, ignoring cin.
REQ-017 In subtract mode, carry_out SHALL be 1 when no borrow occurs (a >= b unsigned).
REQ-018 Overflow SHALL be 1 when both effective operands (a, and b or ~b) have equal sign bits and the sum sign bit differs from them.
REQ-019 Stage 1 SHALL register per-bit generate (a&b') and propagate (a|b'), where b' is the effective operand; it SHALL also register per-group generate/propagate and the effective carry-in.
REQ-020 Stage 2 SHALL derive every group carry-in by lookahead from the group G/P and the effective carry-in, with no bit-serial ripple across groups; it SHALL register sum, carry_out, overflow and zero.
REQ-021 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held at 1.
REQ-022 Throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-023 Each stage SHALL hold a valid bit; stage 2 SHALL advance when it is empty or out_ready is 1.
REQ-024 Stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-025 in_ready SHALL equal the stage-1 advance condition and SHALL be combinational on out_ready.
REQ-026 While out_valid is 1 and out_ready is 0, sum_output, overflow and zero SHALL stay stable.
REQ-027 Results SHALL emerge in acceptance order, with none dropped or duplicated; at most 2 operations SHALL be in flight.
REQ-028 While in_valid is 0, the module SHALL ignore a, b, cin and sub.
REQ-029 A simultaneous input and output transfer on a full pipeline SHALL keep the occupancy at 2.

Reset
REQ-030 While rst is 1, out_valid, both stage valid bits, sum_output, overflow and zero SHALL be 0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after reset is released.
REQ-032 in_ready SHALL be 1 in the first cycle after rst is deasserted.

Verification (WIDTH=16, BLOCK=4)
REQ-033 The bench SHALL drive add 0xFFFF+0x0001, cin=0 -> after 2 cycles sum_output=0x1_0000, zero=1, overflow=0.
REQ-034 The bench SHALL drive add 0x7FFF+0x0001, cin=0 -> sum_output=0x0_8000, overflow=1; then add 0x1234+0x4321, cin=1 -> 0x0_5556.
REQ-035 The bench SHALL drive subtract 0x0005-0x0007 -> sum_output=0x0_FFFE, carry_out=0; then subtract 0x8000-0x0001 -> 0x1_7FFF, overflow=1.
REQ-036 The bench SHALL hold out_ready=0 and offer 3 back-to-back operations -> exactly 2 accepted, in_ready=0, outputs stable; then raise out_ready -> results in order at one per cycle.
REQ-037 The bench SHALL assert rst with 2 operations in flight -> out_valid=0 immediately; after release, no stale result appears.
REQ-038 The bench SHALL run 10k random operations with random in_valid/out_ready against a behavioural model -> all fields match and result count equals accepted count.
